bvudiv_ne_checker: RTL and testbench

- Sequential checker for the invertibility condition "x bvudiv s != t" over W-bit bit-vectors, using SMT-LIB division semantics.
- Consumes (s, t, x) triples, for example from the 4-bit Skolem-function netlists, where s={i3..i0}, t={i7..i4} and x={i11..i8}.
- Computes q = x udiv s with a radix-2 restoring divider and reports whether the candidate x satisfies the condition.
- Sits downstream of the combinational Skolem blocks as the verifying end of the same s/t/x interface.

---
 rtl/bv_check_pkg.sv | 14 +
 rtl/udiv_step.sv | 22 ++
 rtl/bvudiv_ne_checker.sv | 97 +++++++++
 tb/tb_bvudiv_ne_checker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bv_check_pkg.sv
// Shared types and constants for the bit-vector division checkers.
// Holds the FSM encoding and the SMT-LIB divide-by-zero quotient constant.
package bv_check_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  // SMT-LIB defines x udiv 0 as all-ones at the operand width
  function automatic logic [63:0] udiv_zero_const(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/udiv_step.sv
// One radix-2 restoring division iteration: shift {r,q} left, subtract s if it fits.
module udiv_step import bv_check_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] q,
  input  logic [W-1:0] s,
  output logic [W-1:0] r_nxt,
  output logic [W-1:0] q_nxt
);

  logic [W:0] sh;
  logic       ge;

  // W+1 bits so the bit shifted out of r still takes part in the compare
  assign sh    = {r, q[W-1]};
  assign ge    = sh >= {1'b0, s};
  // when ge the true difference is < s, so W-bit wraparound subtraction is exact
  assign r_nxt = ge ? (sh[W-1:0] - s) : sh[W-1:0];
  assign q_nxt = {q[W-2:0], ge};

endmodule

// File: rtl/bvudiv_ne_checker.sv
// Sequential checker for "x bvudiv s != t": restoring divider, valid/ready
// handshakes on both sides and a saturating count of failing candidates.
module bvudiv_ne_checker import bv_check_pkg::*; #(
  parameter int W     = W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     s,
  input  logic [W-1:0]     t,
  input  logic [W-1:0]     x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     quot,
  output logic [W-1:0]     rem,
  output logic             ok,
  output logic [CNT_W-1:0] fail_count
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] DIV0_Q = W'(udiv_zero_const(W));

  state_t         state, state_nxt;
  logic [W-1:0]   s_q, t_q, r_q, q_q;
  logic [W-1:0]   r_n, q_n;
  logic [CW-1:0]  cnt;
  logic [CNT_W-1:0] fails;

  udiv_step #(.W(W)) u_step (
    .r     (r_q),
    .q     (q_q),
    .s     (s_q),
    .r_nxt (r_n),
    .q_nxt (q_n)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (s == '0) ? DONE : DIV;
      end
      DIV:  if (cnt == '0) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign quot       = q_q;
  assign rem        = r_q;
  assign ok         = out_valid && (q_q != t_q);
  assign fail_count = fails;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s_q   <= '0;
      t_q   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      cnt   <= '0;
      fails <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (in_valid) begin
          s_q <= s;
          t_q <= t;
          if (s == '0) begin
            q_q <= DIV0_Q;
            r_q <= x;
          end else begin
            q_q <= x;
            r_q <= '0;
            cnt <= CW'(W - 1);
          end
        end
        DIV: begin
          r_q <= r_n;
          q_q <= q_n;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: if (out_ready && !ok && fails != '1) fails <= fails + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bvudiv_ne_checker.sv
// Directed bench for bvudiv_ne_checker: hand-computed vectors, back-pressure,
// mid-division reset, exhaustive W=4 sweep and counter saturation.
module tb_bvudiv_ne_checker;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [3:0] s, t, x;
  logic       in_ready, out_valid, ok;
  logic [3:0] quot, rem;
  logic [15:0] fail_count;
  logic       in_ready2, out_valid2, ok2;
  logic [3:0] quot2, rem2;
  logic [1:0] fail_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bvudiv_ne_checker #(.W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .t(t), .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .ok(ok), .fail_count(fail_count)
  );

  bvudiv_ne_checker #(.W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .s(s), .t(t), .x(x), .out_valid(out_valid2), .out_ready(out_ready),
    .quot(quot2), .rem(rem2), .ok(ok2), .fail_count(fail_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One transaction: wait for in_ready, accept, measure latency, hold
  // out_ready low for `hold` cycles, then complete the output transfer.
  task automatic op(input logic [3:0] si, ti, xi, input int hold, input bit verbose,
                    output logic [3:0] q_o, r_o, output logic ok_o, output int lat);
    int n;
    @(negedge clk);
    s = si; t = ti; x = xi; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; s = ~si; t = ~ti; x = ~xi;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    if (lat >= 20) chk("out_valid_timeout", 0, 1);
    q_o = quot; r_o = rem; ok_o = ok;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (verbose) begin
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_quot_stable", quot, q_o);
        chk("bp_rem_stable", rem, r_o);
        chk("bp_ok_stable", ok, ok_o);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (verbose) begin
      chk("post_xfer_out_valid", out_valid, 0);
      chk("post_xfer_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    logic [3:0] q, r;
    logic       okv;
    int         lat, exp_fails;
    logic [3:0] eq, er;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; s = '0; t = '0; x = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quot", quot, 0);
    chk("reset_rem", rem, 0);
    chk("reset_ok", ok, 0);
    chk("reset_fail_count", fail_count, 0);

    // 13 / 3 = 4 r 1, t=4 -> fails the condition
    op(4'd3, 4'd4, 4'd13, 0, 1'b1, q, r, okv, lat);
    chk("basic_quot", q, 4);
    chk("basic_rem", r, 1);
    chk("basic_ok", okv, 0);
    chk("basic_lat", lat, 5);
    chk("basic_fail_count", fail_count, 1);

    // divide by zero: quot all-ones, rem = x, single-cycle latency
    op(4'd0, 4'd15, 4'd9, 0, 1'b1, q, r, okv, lat);
    chk("div0_quot", q, 15);
    chk("div0_rem", r, 9);
    chk("div0_ok", okv, 0);
    chk("div0_lat", lat, 1);
    chk("div0_fail_count", fail_count, 2);

    op(4'd0, 4'd0, 4'd9, 0, 1'b1, q, r, okv, lat);
    chk("div0_t0_ok", okv, 1);
    chk("div0_t0_fail_count", fail_count, 2);

    // back-pressure: 15 / 2 = 7 r 1
    op(4'd2, 4'd0, 4'd15, 6, 1'b1, q, r, okv, lat);
    chk("bp_quot", q, 7);
    chk("bp_rem", r, 1);
    chk("bp_ok", okv, 1);
    chk("bp_fail_count", fail_count, 2);

    // reset on the second DIV cycle aborts the division
    @(negedge clk);
    s = 4'd5; t = 4'd0; x = 4'd14; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_fail_count", fail_count, 0);
    begin
      int seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      out_ready = 1'b0;
      chk("abort_no_result", seen, 0);
    end

    // exhaustive W=4 sweep against a reference divider
    exp_fails = 0;
    for (int si = 0; si < 16; si++)
      for (int ti = 0; ti < 16; ti++)
        for (int xi = 0; xi < 16; xi++) begin
          op(4'(si), 4'(ti), 4'(xi), 0, 1'b0, q, r, okv, lat);
          eq = (si == 0) ? 4'd15 : 4'(xi / si);
          er = (si == 0) ? 4'(xi) : 4'(xi % si);
          if (eq == 4'(ti)) exp_fails++;
          chk("sweep_quot", q, eq);
          chk("sweep_rem", r, er);
          chk("sweep_ok", okv, eq != 4'(ti));
        end
    chk("sweep_fail_count", fail_count, exp_fails);

    // saturation on the 2-bit counter instance
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("sat_reset", fail_count2, 0);
    op(4'd1, 4'd6, 4'd6, 0, 1'b0, q, r, okv, lat); chk("sat_1", fail_count2, 1);
    op(4'd1, 4'd6, 4'd6, 0, 1'b0, q, r, okv, lat); chk("sat_2", fail_count2, 2);
    op(4'd1, 4'd6, 4'd6, 0, 1'b0, q, r, okv, lat); chk("sat_3", fail_count2, 3);
    op(4'd1, 4'd6, 4'd6, 0, 1'b0, q, r, okv, lat); chk("sat_4", fail_count2, 3);
    op(4'd1, 4'd6, 4'd6, 0, 1'b0, q, r, okv, lat); chk("sat_5", fail_count2, 3);
    chk("sat_quot", q, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
